// File: rtl/chunk_streamer.sv
// chunk_streamer: serializes one bram chunk into elem_bits-wide elements,
// element 0 first, with partial lengths, backpressure and abort.
module chunk_streamer #(
  parameter  int num_bits  = 512,
  parameter  int elem_bits = 8,
  localparam int NUM_ELEMS = num_bits / elem_bits,
  localparam int IDX_W     = $clog2(NUM_ELEMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [num_bits-1:0]  chunk_in,
  input  logic [IDX_W:0]       chunk_len,
  input  logic                 chunk_valid,
  output logic                 chunk_ready,
  output logic [elem_bits-1:0] elem_out,
  output logic                 elem_valid,
  input  logic                 elem_ready,
  output logic [IDX_W-1:0]     elem_index,
  output logic                 elem_last,
  output logic                 busy,
  input  logic                 abort
);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  localparam logic [IDX_W:0] LEN_MAX =
    (IDX_W+1)'(NUM_ELEMS);
  localparam logic [IDX_W:0] ONE =
    (IDX_W+1)'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [num_bits-1:0] r_shreg;
  logic [IDX_W:0]      r_len;
  logic [IDX_W-1:0]    r_idx;
  logic                r_valid;
  logic                r_last;

  logic [IDX_W:0] w_eff_len;
  logic [IDX_W:0] w_idx_inc;
  logic           w_beat;
  logic           w_ready;
  logic           w_accept;

  // zero and oversize lengths both mean a full chunk
  assign w_eff_len =
    (chunk_len == '0 || chunk_len > LEN_MAX)
      ? LEN_MAX : chunk_len;

  assign w_beat    = r_valid && elem_ready;
  assign w_ready   = rst && !abort &&
    (r_state == S_IDLE || (w_beat && r_last));
  assign w_accept  = chunk_valid && w_ready;
  assign w_idx_inc = {1'b0, r_idx} + ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort)
      w_state_nxt = S_IDLE;
    else if (w_accept)
      w_state_nxt = S_STREAM;
    else if (w_beat && r_last)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (abort) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_shreg <= chunk_in;
      r_len   <= w_eff_len;
      r_idx   <= '0;
      r_valid <= 1'b1;
      r_last  <= (w_eff_len == ONE);
    end else if (w_beat) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_shreg <= {{elem_bits{1'b0}},
                    r_shreg[num_bits-1:elem_bits]};
        r_idx   <= r_idx + 1'b1;
        r_last  <= (w_idx_inc == r_len - ONE);
      end
    end
  end

  assign chunk_ready = w_ready;
  assign elem_out    = r_shreg[elem_bits-1:0];
  assign elem_valid  = r_valid;
  assign elem_index  = r_idx;
  assign elem_last   = r_last;
  assign busy        = (r_state == S_STREAM);

endmodule

// File: doc/chunk_streamer.md
Name: chunk_streamer

Overview:
Downstream stage of the local-memory bram. Takes one num_bits-wide chunk (the bram's chunk_out) over a valid/ready handshake and emits it as a stream of elem_bits-wide elements, element 0 first, to the compute datapath. It supports partial-chunk lengths, downstream backpressure, back-to-back chunks with no bubble, and a synchronous abort.

Parameters:
num_bits, 512, chunk width; must be a multiple of elem_bits.
elem_bits, 8, element width; matches the bram host byte width.
(derived, not overridable) num_elems = num_bits/elem_bits = 64; idx_w = clog2(num_elems) = 6.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
chunk_in  input  num_bits  chunk to stream; element k = chunk_in[k*elem_bits +: elem_bits].
chunk_len  input  idx_w+1  number of elements to emit; sampled with the chunk; 0 means num_elems; values above num_elems are clamped to num_elems.
chunk_valid  input  1  chunk_in/chunk_len valid.
chunk_ready  output  1  block can accept a chunk this cycle.
elem_out  output  elem_bits  current element.
elem_valid  output  1  elem_out valid.
elem_ready  input  1  consumer accepts elem_out.
elem_index  output  idx_w  index of the current element within its chunk.
elem_last  output  1  current element is the final one of the chunk.
busy  output  1  high in STREAM.
abort  input  1  synchronous flush.

Behaviour:
- FSM has two states: IDLE and STREAM. Registers: shreg[num_bits], len, elem_index, elem_valid, elem_last, state.
- Reset (rst low, asynchronous): state=IDLE; shreg, len, elem_index = 0; elem_valid, elem_last, busy = 0; elem_out = 0. chunk_ready = 0 while rst is low and 1 after release.
- elem_out = shreg[elem_bits-1:0] at all times. It is meaningful only when elem_valid=1.
- chunk_ready (combinational) = rst && !abort && (state==IDLE || (elem_valid && elem_ready && elem_last)).
- Chunk accept means chunk_valid && chunk_ready at an edge. On accept: shreg <= chunk_in; len <= effective length; elem_index <= 0; elem_valid <= 1; elem_last <= (effective length==1); state <= STREAM.
- Latency: the first element is valid in the cycle right after the accept edge.
- Beat means elem_valid && elem_ready at an edge. On a beat that is not last: shreg shifts right by elem_bits with zero fill; elem_index increments; elem_last <= (elem_index+1 == len-1).
- On a last beat with no simultaneous accept: elem_valid <= 0, elem_last <= 0, state <= IDLE.
- On a last beat with a simultaneous accept: the accept rule applies, so there is no bubble between chunks.
- When elem_ready=0, elem_out, elem_index, elem_last and elem_valid hold exactly.
- chunk_valid while busy, other than on the last beat, is ignored. Upstream must hold the chunk.
- abort=1 at an edge (priority over beat and accept): elem_valid, elem_last <= 0; elem_index <= 0; state <= IDLE. shreg is left as is. The pending element is dropped.
- Asynchronous reset mid-stream returns all outputs to reset values immediately. No element is emitted afterwards until a new accept.
- busy = (state==STREAM).
- Throughput: one element per cycle when elem_ready is held high.

Test Plan:
1. Reset: drive rst low mid-simulation -> elem_valid, elem_last, busy, elem_out, elem_index all 0 and chunk_ready 0 asynchronously; release rst -> chunk_ready=1.
2. Full chunk: byte k = k+1 (0x01..0x40), chunk_len=0, elem_ready held 1 -> 64 consecutive beats, elem_out 0x01..0x40, elem_index 0..63, elem_last only with 0x40, chunk_ready=1 during that beat, busy=0 afterwards.
3. Backpressure: same chunk, elem_ready alternating 1,0 -> elem_out/elem_index stable across every ready=0 cycle; sequence 0x01..0x40 intact; completes in 128 cycles.
4. Partial and clamped lengths: bytes 0xAA,0x55,0x3C,0x99..., chunk_len=3 -> emits 0xAA,0x55,0x3C with elem_last on 0x3C, then IDLE. chunk_len=1 -> single beat with elem_last=1. chunk_len=100 -> 64 beats.
5. Back-to-back: chunk B (byte k = 0x80+k) valid during chunk A's last beat -> accepted on that edge; 0x80 valid in the next cycle with elem_index=0; no idle cycle between chunks.
6. Abort: assert abort for one cycle at elem_index=10 with a chunk_valid pending -> elem_valid=0 the next cycle, that chunk not accepted (chunk_ready=0 during abort), chunk_ready=1 the following cycle, a new chunk streams from index 0.
